// File: rtl/virtio_used_ring_handler_main.sv
// virtio_used_ring_handler_main
//   Device-side used ring writer. Completed descriptor chains arrive on rx and
//   are published to the driver as an in-order request stream on tx. Each
//   element becomes a WRITE_RING request. The new used idx is then published
//   with WRITE_IDX. The driver's suppression state is read back with
//   READ_FLAGS or READ_USED_EVENT, and an interrupt is raised only when the
//   virtio notification rules ask for one.
//
// Ports
//   aclk, areset        clock, asynchronous active-high reset
//   configure_*         [15:0] initial used idx, [16] event_idx enable,
//                       [17] load_idx (honoured only while idle)
//   rx_*                completed element {len[31:0], id[31:0]}
//   tx_*                memory request, tid = request type,
//                       tdata = {element[63:0], offset[15:0]}
//   response_*          16-bit value returned by a flags/used_event read
//   interrupt_*         driver interrupt request
module virtio_used_ring_handler_main #(
    parameter int MAX_BURST_TRANSACTIONS = 16
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        configure_tvalid,
    output logic        configure_tready,
    input  logic [17:0] configure_tdata,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    input  logic [63:0] rx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    output logic [1:0]  tx_tid,
    output logic [79:0] tx_tdata,
    input  logic        response_tvalid,
    output logic        response_tready,
    input  logic [15:0] response_tdata,
    output logic        interrupt_tvalid,
    input  logic        interrupt_tready
);

    if (MAX_BURST_TRANSACTIONS < 1 || MAX_BURST_TRANSACTIONS > 65535) begin : g_bad_max
        $error("MAX_BURST_TRANSACTIONS must lie in 1..65535");
    end

    localparam logic [15:0] LP_MAX_BURST = 16'(MAX_BURST_TRANSACTIONS);

    localparam logic [1:0] TID_WRITE_RING      = 2'd0;
    localparam logic [1:0] TID_WRITE_IDX       = 2'd1;
    localparam logic [1:0] TID_READ_FLAGS      = 2'd2;
    localparam logic [1:0] TID_READ_USED_EVENT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RING,
        S_IDX,
        S_NOTIFY,
        S_WAIT,
        S_INTERRUPT
    } state_t;

    state_t      r_state;
    logic [15:0] r_ring_idx;    // next ring slot to be written
    logic [15:0] r_used_idx;    // last used idx published to the driver
    logic [15:0] r_old_idx;     // used idx published before r_used_idx
    logic [15:0] r_burst_count;
    logic        r_event_idx;

    logic w_free;
    logic w_rx_hs;
    logic w_need;

    // Decide whether the driver wants to be notified.
    // Flags mode: notify unless NO_INTERRUPT (bit 0) is set.
    // Event mode: notify when used_event falls among the entries just
    // published, i.e. the virtio vring_need_event() test in 16-bit arithmetic.
    function automatic logic f_need(input logic        ev,
                                    input logic [15:0] used_idx,
                                    input logic [15:0] old_idx,
                                    input logic [15:0] resp);
        logic [15:0] v_dist_event;
        logic [15:0] v_dist_old;
        v_dist_event = used_idx - resp - 16'd1;
        v_dist_old   = used_idx - old_idx;
        if (ev) begin
            return v_dist_event < v_dist_old;
        end
        return !resp[0];
    endfunction

    // The tx register can take a new request when empty or draining this cycle.
    assign w_free          = !tx_tvalid || tx_tready;
    assign rx_tready       = (r_state == S_RING) && w_free && (r_burst_count < LP_MAX_BURST);
    assign w_rx_hs         = rx_tvalid && rx_tready;
    assign response_tready = (r_state == S_WAIT);
    assign w_need          = f_need(r_event_idx, r_used_idx, r_old_idx, response_tdata);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state          <= S_IDLE;
            r_ring_idx       <= '0;
            r_used_idx       <= '0;
            r_old_idx        <= '0;
            r_burst_count    <= '0;
            r_event_idx      <= 1'b0;
            configure_tready <= 1'b0;
            tx_tvalid        <= 1'b0;
            tx_tid           <= '0;
            tx_tdata         <= '0;
            interrupt_tvalid <= 1'b0;
        end else begin
            configure_tready <= 1'b1;

            if (configure_tvalid && configure_tready) begin
                r_event_idx <= configure_tdata[16];
                if (configure_tdata[17] && (r_state == S_IDLE)) begin
                    r_ring_idx <= configure_tdata[15:0];
                    r_used_idx <= configure_tdata[15:0];
                end
            end

            // Drop valid on acceptance; a request issued below overrides this.
            if (tx_tvalid && tx_tready) begin
                tx_tvalid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (rx_tvalid) begin
                        r_state <= S_RING;
                    end
                end

                S_RING: begin
                    if (w_rx_hs) begin
                        tx_tvalid     <= 1'b1;
                        tx_tid        <= TID_WRITE_RING;
                        tx_tdata      <= {rx_tdata, r_ring_idx};
                        r_ring_idx    <= r_ring_idx + 16'd1;
                        r_burst_count <= r_burst_count + 16'd1;
                    end else if (w_free && (!rx_tvalid || (r_burst_count == LP_MAX_BURST))) begin
                        r_state <= S_IDX;
                    end
                end

                S_IDX: begin
                    if (w_free) begin
                        tx_tvalid     <= 1'b1;
                        tx_tid        <= TID_WRITE_IDX;
                        tx_tdata      <= {64'd0, r_ring_idx};
                        r_old_idx     <= r_used_idx;
                        r_used_idx    <= r_ring_idx;
                        r_burst_count <= '0;
                        r_state       <= S_NOTIFY;
                    end
                end

                S_NOTIFY: begin
                    if (w_free) begin
                        tx_tvalid <= 1'b1;
                        tx_tid    <= r_event_idx ? TID_READ_USED_EVENT : TID_READ_FLAGS;
                        tx_tdata  <= '0;
                        r_state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (response_tvalid) begin
                        if (w_need) begin
                            interrupt_tvalid <= 1'b1;
                            r_state          <= S_INTERRUPT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_INTERRUPT: begin
                    if (interrupt_tready) begin
                        interrupt_tvalid <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_virtio_used_ring_handler_main.sv
// tb_virtio_used_ring_handler_main
//   Directed and randomized stimulus for the used ring writer. The reference
//   model turns a list of completed elements into the expected request list
//   (bursts of at most MAXB ring writes, each followed by an idx publish and
//   a suppression read) and decides interrupts from the used_event window.
module tb_virtio_used_ring_handler_main;

    localparam int MAXB = 16;

    logic        aclk = 1'b0;
    logic        areset;
    logic        configure_tvalid;
    logic        configure_tready;
    logic [17:0] configure_tdata;
    logic        rx_tvalid;
    logic        rx_tready;
    logic [63:0] rx_tdata;
    logic        tx_tvalid;
    logic        tx_tready = 1'b0;
    logic [1:0]  tx_tid;
    logic [79:0] tx_tdata;
    logic        response_tvalid;
    logic        response_tready;
    logic [15:0] response_tdata;
    logic        interrupt_tvalid;
    logic        interrupt_tready;

    virtio_used_ring_handler_main #(.MAX_BURST_TRANSACTIONS(MAXB)) dut (
        .aclk             (aclk),
        .areset           (areset),
        .configure_tvalid (configure_tvalid),
        .configure_tready (configure_tready),
        .configure_tdata  (configure_tdata),
        .rx_tvalid        (rx_tvalid),
        .rx_tready        (rx_tready),
        .rx_tdata         (rx_tdata),
        .tx_tvalid        (tx_tvalid),
        .tx_tready        (tx_tready),
        .tx_tid           (tx_tid),
        .tx_tdata         (tx_tdata),
        .response_tvalid  (response_tvalid),
        .response_tready  (response_tready),
        .response_tdata   (response_tdata),
        .interrupt_tvalid (interrupt_tvalid),
        .interrupt_tready (interrupt_tready)
    );

    always #5 aclk = ~aclk;

    int          checks = 0;
    int          errors = 0;
    int          tx_mode = 0;      // 0 always ready, 1 random, 2 held low
    int          rx_acc = 0;
    logic [81:0] tx_q[$];
    logic [63:0] el_q[$];
    logic [15:0] rsp_q[$];
    logic [15:0] m_idx = 16'd0;
    logic        m_ev = 1'b0;
    logic        prev_stall = 1'b0;
    logic [81:0] prev_req = '0;

    task automatic check(input string tag, input logic [81:0] obs, input logic [81:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    always @(posedge aclk) begin
        #1;
        case (tx_mode)
            0:       tx_tready = 1'b1;
            1:       tx_tready = ($urandom_range(0, 3) != 0);
            default: tx_tready = 1'b0;
        endcase
    end

    // Captures accepted requests and checks that a stalled request holds.
    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("tx_hold_valid", tx_tvalid, 1);
                check("tx_hold_data", {tx_tid, tx_tdata}, prev_req);
            end
            if (tx_tvalid && tx_tready) tx_q.push_back({tx_tid, tx_tdata});
            if (rx_tvalid && rx_tready) rx_acc++;
            prev_stall = tx_tvalid && !tx_tready;
            prev_req   = {tx_tid, tx_tdata};
        end
    end

    task automatic cfg(input logic [15:0] idx, input logic ev, input logic load);
        tick();
        configure_tvalid = 1'b1;
        configure_tdata  = {load, ev, idx};
        tick();
        configure_tvalid = 1'b0;
        m_ev = ev;
        if (load) m_idx = idx;
    endtask

    task automatic send_elems();
        int   k = 0;
        int   guard = 0;
        logic hs;
        if (el_q.size() == 0) return;
        tick();
        rx_tvalid = 1'b1;
        rx_tdata  = el_q[0];
        while (k < el_q.size()) begin
            @(negedge aclk);
            hs = rx_tready;
            tick();
            guard++;
            if (hs) begin
                k++;
                if (k < el_q.size()) rx_tdata = el_q[k];
                else rx_tvalid = 1'b0;
            end
            if (guard > 5000) begin
                check("rx_timeout", k, el_q.size());
                rx_tvalid = 1'b0;
                break;
            end
        end
    endtask

    task automatic serve(input logic [15:0] rsp, input logic need, input string tag);
        int g = 0;
        do begin
            @(negedge aclk);
            g++;
        end while (!response_tready && g < 3000);
        if (!response_tready) begin
            check({tag, "_resp_timeout"}, response_tready, 1);
            return;
        end
        tick();
        response_tvalid = 1'b1;
        response_tdata  = rsp;
        tick();
        response_tvalid = 1'b0;
        @(negedge aclk);
        check({tag, "_irq"}, interrupt_tvalid, need);
        if (interrupt_tvalid) begin
            repeat ($urandom_range(0, 2)) tick();
            tick();
            interrupt_tready = 1'b1;
            tick();
            interrupt_tready = 1'b0;
            @(negedge aclk);
            check({tag, "_irq_clear"}, interrupt_tvalid, 0);
        end
    endtask

    // Builds the expected request list for el_q, drives it, and compares.
    task automatic run_scenario(input string tag, input bit rnd, input bit rst_wait);
        logic [81:0] exp_q[$];
        logic        need_q[$];
        logic [15:0] base, nw, x, d;
        int          n, c, len, g, lim;
        n = el_q.size();
        c = 0;
        base = m_idx;
        if (rnd) rsp_q.delete();
        while (c * MAXB < n) begin
            len = (n - c * MAXB > MAXB) ? MAXB : n - c * MAXB;
            for (int j = 0; j < len; j++) exp_q.push_back({2'd0, el_q[c * MAXB + j], 16'(base + 16'(j))});
            nw = base + 16'(len);
            exp_q.push_back({2'd1, 64'd0, nw});
            exp_q.push_back({(m_ev ? 2'd3 : 2'd2), 80'd0});
            if (rnd) rsp_q.push_back(m_ev ? 16'(base + 16'($urandom_range(0, 2 * len))) : 16'($urandom));
            if (m_ev) begin
                x = rsp_q[c] - base;    // used_event relative to the old idx
                d = nw - base;          // entries published in this burst
                need_q.push_back(x < d);
            end else begin
                need_q.push_back(rsp_q[c][0] == 1'b0);
            end
            base = nw;
            c++;
        end
        m_idx = base;
        tx_q.delete();
        if (!rst_wait) begin
            fork
                send_elems();
                begin
                    for (int i = 0; i < c; i++) serve(rsp_q[i], need_q[i], tag);
                end
            join
            g = 0;
            do begin
                @(negedge aclk);
                g++;
            end while (tx_tvalid && g < 500);
        end else begin
            fork
                send_elems();
                begin
                    g = 0;
                    do begin
                        @(negedge aclk);
                        g++;
                    end while (!response_tready && g < 2000);
                end
            join
            check({tag, "_reached_wait"}, response_tready, 1);
            tick();
        end
        check({tag, "_req_count"}, tx_q.size(), exp_q.size());
        lim = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            if (exp_q[i][81:80] >= 2'd2) check({tag, "_read_type"}, tx_q[i][81:80], exp_q[i][81:80]);
            else check({tag, "_req"}, tx_q[i], exp_q[i]);
        end
        if (rst_wait) begin
            areset = 1'b1;
            @(negedge aclk);
            check("rst_mid_ctrl", {configure_tready, rx_tready, tx_tvalid, response_tready,
                                   interrupt_tvalid, tx_tid}, 0);
            check("rst_mid_tdata", tx_tdata, 0);
            tick();
            areset = 1'b0;
            m_idx = 16'd0;
            m_ev  = 1'b0;
        end
    endtask

    task automatic stall_mid_burst();
        int g = 0;
        int acc;
        while (rx_acc < 2 && g < 500) begin
            @(negedge aclk);
            g++;
        end
        tx_mode = 2;
        @(negedge aclk);
        acc = rx_acc;
        repeat (5) begin
            @(negedge aclk);
            check("stall_valid", tx_tvalid, 1);
            check("stall_rx_ready", rx_tready, 0);
        end
        check("stall_no_accept", rx_acc, acc);
        tx_mode = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        areset           = 1'b1;
        configure_tvalid = 1'b0;
        configure_tdata  = '0;
        rx_tvalid        = 1'b0;
        rx_tdata         = '0;
        response_tvalid  = 1'b0;
        response_tdata   = '0;
        interrupt_tready = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset_ctrl", {configure_tready, rx_tready, tx_tvalid, response_tready,
                             interrupt_tvalid, tx_tid}, 0);
        check("reset_tdata", tx_tdata, 0);
        tick();
        areset = 1'b0;
        @(negedge aclk);
        check("cfg_ready_release", configure_tready, 0);
        @(negedge aclk);
        check("cfg_ready_after", configure_tready, 1);

        // Single element, flags clear -> interrupt.
        cfg(16'h0000, 1'b0, 1'b1);
        el_q = '{64'h0000_0040_0000_0003};
        rsp_q = '{16'h0000};
        run_scenario("single_irq", 1'b0, 1'b0);

        // Same element, NO_INTERRUPT set -> no interrupt, continues at offset 1.
        rsp_q = '{16'h0001};
        run_scenario("single_noirq", 1'b0, 1'b0);

        // 20 back-to-back elements split at the burst limit.
        cfg(16'h0000, 1'b0, 1'b1);
        el_q.delete();
        for (int i = 0; i < 20; i++) el_q.push_back({$urandom, $urandom});
        run_scenario("burst20", 1'b1, 1'b0);

        // Event idx: used_event inside / outside the published window.
        cfg(16'h0000, 1'b1, 1'b1);
        el_q.delete();
        for (int i = 0; i < 3; i++) el_q.push_back({$urandom, $urandom});
        rsp_q = '{16'h0001};
        run_scenario("event_hit", 1'b0, 1'b0);
        cfg(16'h0000, 1'b1, 1'b1);
        rsp_q = '{16'h0005};
        run_scenario("event_miss", 1'b0, 1'b0);

        // Index wrap through 0xFFFF.
        cfg(16'hFFFE, 1'b1, 1'b1);
        rsp_q = '{16'hFFFF};
        run_scenario("wrap", 1'b0, 1'b0);

        // Randomized traffic with random downstream back-pressure.
        tx_mode = 1;
        for (int r = 0; r < 10; r++) begin
            cfg(16'($urandom), 1'($urandom), 1'($urandom));
            el_q.delete();
            for (int i = 0; i < $urandom_range(1, 40); i++) el_q.push_back({$urandom, $urandom});
            run_scenario("random", 1'b1, 1'b0);
        end
        tx_mode = 0;

        // Downstream stall mid-burst, then reset while waiting for the read.
        cfg(16'h0000, 1'b0, 1'b1);
        el_q.delete();
        for (int i = 0; i < 6; i++) el_q.push_back({$urandom, $urandom});
        rx_acc = 0;
        fork
            run_scenario("stall_reset", 1'b0, 1'b1);
            stall_mid_burst();
        join

        // After reset the ring starts again from idx 0.
        el_q = '{64'h0000_0010_0000_0007};
        rsp_q = '{16'h0001};
        run_scenario("after_reset", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/virtio_used_ring_handler_main.md
Name: virtio_used_ring_handler_main

Overview:
Device-side used ring writer, the counterpart of the available ring handler: it consumes completed descriptor chains and publishes them to the driver.
- Each completed element becomes an in-order AXI4-Stream memory request: element write first, then a used idx update.
- It then reads the driver's suppression state (avail flags or used_event) and raises an interrupt request only when the virtio rules require one.
- It sits between the descriptor completion path and the virtqueue memory request arbiter.

Parameters:
MAX_BURST_TRANSACTIONS, 16, maximum elements written before used idx is forcibly published; must be >= 1 and <= 65535 (DRC).

Ports:
aclk  input  1  clock
areset  input  1  asynchronous active-high reset
configure_tvalid  input  1  configuration valid
configure_tready  output  1  configuration ready
configure_tdata  input  18  [15:0] initial used idx, [16] event_idx enable, [17] load_idx
rx_tvalid  input  1  used element valid
rx_tready  output  1  used element ready
rx_tdata  input  64  used element, {len[31:0], id[31:0]}
tx_tvalid  output  1  memory request valid
tx_tready  input  1  memory request ready
tx_tid  output  2  request type: 0 WRITE_RING, 1 WRITE_IDX, 2 READ_FLAGS, 3 READ_USED_EVENT
tx_tdata  output  80  {element[63:0], offset[15:0]}
response_tvalid  input  1  read response valid
response_tready  output  1  read response ready
response_tdata  input  16  value returned by READ_FLAGS or READ_USED_EVENT
interrupt_tvalid  output  1  driver interrupt request
interrupt_tready  input  1  interrupt accepted

Behaviour:
- Reset values, all to 0: every output, ring_idx, used_idx, old_idx, burst_count, event_idx.
- Reset entry: state returns to IDLE immediately; reset is asynchronous, so a reset mid-operation also cancels any pending request, response or interrupt.
- configure_tready is registered 1 from the first clock after reset release.
- On configure_tvalid:
  - event_idx is always updated.
  - When load_idx=1 and state is IDLE, ring_idx and used_idx load [15:0]. Otherwise the load is ignored.
- tx slot free: free = !tx_tvalid || tx_tready. tx_tid and tx_tdata hold stable while tx_tvalid && !tx_tready.
- tx_tvalid clears on a handshake when no new request is issued that cycle.
- FSM IDLE: rx_tvalid -> RING.
- FSM RING:
  - rx_tready = free && burst_count < MAX_BURST_TRANSACTIONS (combinational).
  - On each rx handshake: tx_tid=WRITE_RING, tx_tdata={rx_tdata, ring_idx}; then ring_idx++ (16-bit, wraps 0xFFFF->0x0000) and burst_count++.
  - Exit to IDX when free && (!rx_tvalid || burst_count == MAX_BURST_TRANSACTIONS).
  - Back-to-back elements sustain 1 element/cycle.
- FSM IDX:
  - When free: issue WRITE_IDX with offset=ring_idx and element=0.
  - Same edge: old_idx<=used_idx, used_idx<=ring_idx, burst_count<=0 -> NOTIFY.
- FSM NOTIFY: when free, issue READ_USED_EVENT if event_idx, else READ_FLAGS, then -> WAIT.
- FSM WAIT:
  - response_tready=1 in this state only; it is 0 everywhere else.
  - On response_tvalid, compute need, then go to INTERRUPT if need, else IDLE.
  - event_idx=0: need = (response_tdata[0] == 0), i.e. NO_INTERRUPT flag clear.
  - event_idx=1: need = (used_idx - response_tdata - 1) < (used_idx - old_idx), all 16-bit modular unsigned.
- FSM INTERRUPT: interrupt_tvalid=1 (registered) until interrupt_tready -> IDLE.
- rx_tready is 0 in every state except RING; elements arriving during IDX/NOTIFY/WAIT/INTERRUPT are back-pressured.
- Request stream is strictly in order. The downstream memory path guarantees all ring writes commit before the WRITE_IDX.

Test Plan:
- Single element rx {len=0x40,id=3}, event_idx=0, response 0x0000 -> WRITE_RING offset 0 element 0x0000_0040_0000_0003; WRITE_IDX offset 1; READ_FLAGS; one interrupt handshake; return to IDLE.
- Same stimulus with response 0x0001 -> no interrupt_tvalid; IDLE; next element uses offset 1.
- 20 back-to-back elements, MAX_BURST_TRANSACTIONS=16 -> WRITE_RING offsets 0..15, WRITE_IDX 16, read/decision, then offsets 16..19, WRITE_IDX 20; no element lost or duplicated.
- event_idx=1, 3 elements from idx 0 -> used_event=1 gives interrupt; used_event=5 gives none.
- Load idx 0xFFFE with event_idx=1, send 3 elements -> offsets 0xFFFE, 0xFFFF, 0x0000; WRITE_IDX 0x0001; used_event=0xFFFF gives interrupt.
- tx_tready held low 5 cycles mid-burst -> tx_tdata/tx_tid stable, rx_tready=0; then areset pulse in WAIT -> all outputs 0, used idx restarts at 0.
